// File: rtl/e203_icb_sram_rsp.sv
// ICB responder backed by a word-organised SRAM with an in-order response FIFO.
// Define E203_ICB_SRAM_RSP_BP_EN to add LFSR-driven random command backpressure.
module e203_icb_sram_rsp #(
    parameter int          AW    = 32,
    parameter int          DEPTH = 256,
    parameter logic [31:0] BASE  = 32'h8000_0000,
    parameter int          OUTS  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          icb_cmd_valid,
    output logic          icb_cmd_ready,
    input  logic [AW-1:0] icb_cmd_addr,
    input  logic          icb_cmd_read,
    input  logic [31:0]   icb_cmd_wdata,
    input  logic [3:0]    icb_cmd_wmask,
    output logic          icb_rsp_valid,
    input  logic          icb_rsp_ready,
    output logic          icb_rsp_err,
    output logic [31:0]   icb_rsp_rdata
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = (OUTS > 1) ? $clog2(OUTS) : 1;
    localparam int CW = $clog2(OUTS + 1);
    // One extra bit so BASE + window size cannot wrap.
    localparam logic [AW:0] LO = (AW+1)'(BASE);
    localparam logic [AW:0] HI = LO + (AW+1)'(4 * DEPTH);

    logic [31:0]   mem_q   [DEPTH];
    logic          err_q   [OUTS];
    logic [31:0]   rdata_q [OUTS];
    logic [PW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q;

    logic          push, pop, hit, aligned, legal, ready_fifo;
    logic [AW-1:0] off;
    logic [IW-1:0] idx;
    logic          err_d;
    logic [31:0]   rdata_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUTS - 1)) ? '0 : p + 1'b1;
    endfunction

    assign hit     = ({1'b0, icb_cmd_addr} >= LO) && ({1'b0, icb_cmd_addr} < HI);
    assign aligned = (icb_cmd_addr[1:0] == 2'b00);
    assign legal   = hit & aligned;
    assign off     = icb_cmd_addr - AW'(BASE);
    assign idx     = IW'(off >> 2);

    assign ready_fifo = (cnt_q < CW'(OUTS));

`ifdef E203_ICB_SRAM_RSP_BP_EN
    logic [15:0] lfsr_q, lfsr_d;
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_ff @(posedge clk) begin
        if (!rst_n) lfsr_q <= 16'hACE1;
        else        lfsr_q <= lfsr_d;
    end

    assign icb_cmd_ready = ready_fifo & lfsr_q[0];
`else
    assign icb_cmd_ready = ready_fifo;
`endif

    assign push = icb_cmd_valid & icb_cmd_ready;
    assign pop  = icb_rsp_valid & icb_rsp_ready;

    always_comb begin
        err_d   = ~legal;
        rdata_d = '0;
        if (legal && icb_cmd_read) rdata_d = mem_q[idx];
    end

    // Memory is deliberately not reset so contents survive a FIFO flush.
    always_ff @(posedge clk) begin
        if (rst_n && push && legal && !icb_cmd_read) begin
            for (int i = 0; i < 4; i++) begin
                if (icb_cmd_wmask[i]) mem_q[idx][8*i +: 8] <= icb_cmd_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                err_q[wptr_q]   <= err_d;
                rdata_q[wptr_q] <= rdata_d;
                wptr_q          <= ptr_inc(wptr_q);
            end
            if (pop) rptr_q <= ptr_inc(rptr_q);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign icb_rsp_valid = (cnt_q != '0);
    assign icb_rsp_err   = icb_rsp_valid ? err_q[rptr_q]   : 1'b0;
    assign icb_rsp_rdata = icb_rsp_valid ? rdata_q[rptr_q] : 32'h0;

endmodule

// File: tb/tb_e203_icb_sram_rsp.sv
// Scoreboard bench for e203_icb_sram_rsp: driver pushes expected responses, monitor pops and compares.
module tb_e203_icb_sram_rsp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
    logic [31:0] icb_cmd_addr, icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic        icb_rsp_valid, icb_rsp_ready, icb_rsp_err;
    logic [31:0] icb_rsp_rdata;

    int vectors = 0;
    int miscompares = 0;
    logic [32:0] sb[$];   // {err, rdata}

    e203_icb_sram_rsp #(.AW(32), .DEPTH(256), .BASE(32'h8000_0000), .OUTS(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
        .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read),
        .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
        .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
        .icb_rsp_err(icb_rsp_err), .icb_rsp_rdata(icb_rsp_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Inputs only ever change #1 after a rising edge; ready is sampled on the falling edge.
    task automatic issue(input logic [31:0] addr, input logic rd, input logic [31:0] wd,
                         input logic [3:0] wm, input logic eerr, input logic [31:0] erd);
        int n = 0;
        icb_cmd_valid = 1'b1;
        icb_cmd_addr  = addr;
        icb_cmd_read  = rd;
        icb_cmd_wdata = wd;
        icb_cmd_wmask = wm;
        forever begin
            @(negedge clk);
            if (icb_cmd_ready) break;
            n++;
            if (n > 50) begin
                vectors++;
                miscompares++;
                $display("FAIL cmd_accept_timeout: addr %h never accepted", addr);
                icb_cmd_valid = 1'b0;
                return;
            end
        end
        sb.push_back({eerr, erd});
        @(posedge clk);
        #1 icb_cmd_valid = 1'b0;
    endtask

    // Monitor: a handshake will occur at the next rising edge.
    always @(negedge clk) begin
        if (icb_rsp_valid === 1'b1 && icb_rsp_ready === 1'b1) begin
            logic [32:0] e;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL rsp_unexpected: err %b rdata %h with empty scoreboard",
                         icb_rsp_err, icb_rsp_rdata);
            end else begin
                e = sb.pop_front();
                if ({icb_rsp_err, icb_rsp_rdata} !== e) begin
                    miscompares++;
                    $display("FAIL rsp_payload: got err %b rdata %h expected err %b rdata %h",
                             icb_rsp_err, icb_rsp_rdata, e[32], e[31:0]);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        icb_cmd_valid = 1'b0; icb_cmd_addr = '0; icb_cmd_read = 1'b0;
        icb_cmd_wdata = '0;   icb_cmd_wmask = '0; icb_rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_cmd_ready", 32'(icb_cmd_ready), 32'd1);
        chk("reset_rsp_valid", 32'(icb_rsp_valid), 32'd0);
        chk("reset_rsp_rdata", icb_rsp_rdata, 32'h0);
        chk("reset_rsp_err",   32'(icb_rsp_err), 32'd0);
        rst_n = 1'b1;
        icb_rsp_ready = 1'b1;
        @(posedge clk); #1;

        // Full write then read-back, with one-cycle latency on an empty FIFO.
        issue(32'h8000_0010, 1'b0, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
        @(negedge clk);
        chk("write_latency_valid", 32'(icb_rsp_valid), 32'd1);
        @(posedge clk); #1;
        issue(32'h8000_0010, 1'b1, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF);
        @(negedge clk);
        chk("read_latency_valid", 32'(icb_rsp_valid), 32'd1);
        @(posedge clk); #1;

        // Partial write, then back-to-back read of the same word.
        issue(32'h8000_0010, 1'b0, 32'h11223344, 4'b0101, 1'b0, 32'h0);
        issue(32'h8000_0010, 1'b1, 32'h0, 4'h0, 1'b0, 32'hDE22BE44);

        // Out-of-range and misaligned, then a legal read.
        issue(32'h8000_0400, 1'b1, 32'h0, 4'h0, 1'b1, 32'h0);
        issue(32'h8000_0002, 1'b1, 32'h0, 4'h0, 1'b1, 32'h0);
        issue(32'h7FFF_FFFC, 1'b1, 32'h0, 4'h0, 1'b1, 32'h0);
        issue(32'h8000_0400, 1'b0, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h0);
        issue(32'h8000_0010, 1'b1, 32'h0, 4'h0, 1'b0, 32'hDE22BE44);

        // Last word of the window, and a zero-mask write being a no-op.
        issue(32'h8000_03FC, 1'b0, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0);
        issue(32'h8000_03FC, 1'b1, 32'h0, 4'h0, 1'b0, 32'hCAFEF00D);
        issue(32'h8000_0010, 1'b0, 32'h55555555, 4'h0, 1'b0, 32'h0);
        issue(32'h8000_0010, 1'b1, 32'h0, 4'h0, 1'b0, 32'hDE22BE44);

        // Backpressure: fill the FIFO, third command must stall.
        issue(32'h8000_0020, 1'b0, 32'hA1A1A1A1, 4'hF, 1'b0, 32'h0);
        issue(32'h8000_0024, 1'b0, 32'hB2B2B2B2, 4'hF, 1'b0, 32'h0);
        issue(32'h8000_0028, 1'b0, 32'hC3C3C3C3, 4'hF, 1'b0, 32'h0);
        repeat (3) @(posedge clk);
        #1 icb_rsp_ready = 1'b0;
        fork
            begin
                issue(32'h8000_0020, 1'b1, 32'h0, 4'h0, 1'b0, 32'hA1A1A1A1);
                issue(32'h8000_0024, 1'b1, 32'h0, 4'h0, 1'b0, 32'hB2B2B2B2);
                issue(32'h8000_0028, 1'b1, 32'h0, 4'h0, 1'b0, 32'hC3C3C3C3);
            end
            begin
                repeat (4) @(negedge clk);
                chk("full_cmd_ready", 32'(icb_cmd_ready), 32'd0);
                chk("full_rsp_valid", 32'(icb_rsp_valid), 32'd1);
                chk("full_head_rdata", icb_rsp_rdata, 32'hA1A1A1A1);
                @(posedge clk);
                #1 icb_rsp_ready = 1'b1;
                @(negedge clk);
                chk("pre_pop_cmd_ready", 32'(icb_cmd_ready), 32'd0);
                @(negedge clk);
                chk("post_pop_cmd_ready", 32'(icb_cmd_ready), 32'd1);
            end
        join
        repeat (4) @(posedge clk);

        // Mid-operation reset drops pending responses, memory survives.
        #1 icb_rsp_ready = 1'b0;
        issue(32'h8000_0010, 1'b1, 32'h0, 4'h0, 1'b0, 32'hDE22BE44);
        issue(32'h8000_0020, 1'b1, 32'h0, 4'h0, 1'b0, 32'hA1A1A1A1);
        @(negedge clk);
        chk("pending_two_ready", 32'(icb_cmd_ready), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("flush_rsp_valid", 32'(icb_rsp_valid), 32'd0);
        chk("flush_cmd_ready", 32'(icb_cmd_ready), 32'd1);
        @(posedge clk);
        #1 icb_rsp_ready = 1'b1;
        issue(32'h8000_0010, 1'b1, 32'h0, 4'h0, 1'b0, 32'hDE22BE44);
        issue(32'h8000_03FC, 1'b1, 32'h0, 4'h0, 1'b0, 32'hCAFEF00D);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/e203_icb_sram_rsp.md
# e203_icb_sram_rsp

ICB target (responder) that terminates one ICB master port of the E203 core (typically `mem_icb` or `fio_icb`) with a word-organised SRAM model. It accepts commands, performs byte-masked writes and word reads, and returns in-order responses through an outstanding-response FIFO, flagging out-of-range or misaligned accesses with `rsp_err`. It is the responder counterpart to the core-side ICB initiator and replaces random response stimulus in core-level benches.

## Interface
- `AW`, 32, command address width
- `DEPTH`, 256, memory depth in 32-bit words (power of two)
- `BASE`, 32'h8000_0000, byte base address of the memory window
- `OUTS`, 2, response FIFO depth (max outstanding transactions, ≥1)

- `clk` in 1: clock
- `rst_n` in 1: reset; one clock; reset is synchronous and active-low
- `icb_cmd_valid` in 1: command valid
- `icb_cmd_ready` out 1: command accept
- `icb_cmd_addr` in AW: byte address
- `icb_cmd_read` in 1: 1 = read, 0 = write
- `icb_cmd_wdata` in 32: write data
- `icb_cmd_wmask` in 4: byte-lane write enables, bit i → bits [8i+7:8i]
- `icb_rsp_valid` out 1: response valid
- `icb_rsp_ready` in 1: response accept
- `icb_rsp_err` out 1: response error
- `icb_rsp_rdata` out 32: read data

## Operation
- Command handshake: accepted at a rising edge where `icb_cmd_valid & icb_cmd_ready`.
- `icb_cmd_ready = (count < OUTS)`; combinational from FIFO count only, no dependence on `icb_cmd_valid` or same-cycle response pop.
- Decode: `hit = addr >= BASE && addr < BASE + 4*DEPTH`; `aligned = addr[1:0] == 0`; index = `(addr - BASE) >> 2`.
- Legal write (hit & aligned): lanes with `wmask[i]=1` updated at acceptance edge; entry {err=0, rdata=0} pushed.
- Legal read: word at index captured at acceptance edge (post any prior write) into entry {err=0, rdata=mem[index]}.
- Illegal (miss or misaligned): memory untouched, entry {err=1, rdata=0} pushed. `wmask=0` write is legal and a no-op.
- Response FIFO: circular, in order; head drives `icb_rsp_*`; pop on `icb_rsp_valid & icb_rsp_ready`.
- Simultaneous push and pop: count unchanged, both pointers advance; wrap-around from OUTS-1 to 0.
- Empty FIFO: `icb_rsp_valid=0`, `icb_rsp_err=0`, `icb_rsp_rdata=0`.
- Memory contents are not reset; unwritten words read undefined. Reset flushes FIFO (pending responses dropped), memory retained.

## Timing
- Reset values: `icb_cmd_ready=1`, `icb_rsp_valid=0`, `icb_rsp_err=0`, `icb_rsp_rdata=0`; count 0, pointers 0.
- Latency: command accepted at edge T → response visible after edge T (`icb_rsp_valid=1` in cycle T+1) when FIFO was empty.
- Throughput: with `icb_rsp_ready` held 1, one command per cycle sustained.
- Backpressure: `icb_rsp_valid` and payload hold stable until popped.
- Full FIFO: `icb_cmd_ready=0` until the cycle after a pop.
- Write at T followed by read of same word at T+1 returns new data.

## Configuration
- `E203_ICB_SRAM_RSP_BP_EN` defined: 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset; advances every cycle) additionally gates `icb_cmd_ready` with `lfsr[0]`; reset value of `icb_cmd_ready` remains 1 (seed bit0 = 1).
- Undefined: no LFSR, `icb_cmd_ready` purely FIFO-count based.

## Test plan
- Reset: hold `rst_n=0` two cycles → `icb_cmd_ready=1`, `icb_rsp_valid=0`, `icb_rsp_rdata=0`, `icb_rsp_err=0`.
- Write 0x8000_0010 data 0xDEADBEEF mask 4'hF, then read same → write rsp err=0 rdata=0; read rsp rdata=0xDEADBEEF one cycle after acceptance.
- Partial write mask 4'b0101 data 0x11223344 over 0xDEADBEEF → read returns 0xDE22BE44.
- Errors: read 0x8000_0400 (DEPTH=256) and read 0x8000_0002 → both err=1 rdata=0; following legal read of 0x8000_0010 unaffected.
- Full/backpressure: `icb_rsp_ready=0`, issue 3 reads back-to-back → 2 accepted, `icb_cmd_ready=0`; raise `icb_rsp_ready` → responses in order, third accepted the cycle after first pop.
- Mid-operation reset with 2 pending responses → FIFO empty, `icb_rsp_valid=0` next cycle; prior written data still readable.
